// File: rtl/latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : latch_write_arbiter
//  Purpose  : Round-robin write sequencer for one shared level-sensitive
//             D-latch. Grants one requester at a time, presents its data on D,
//             pulses the latch enable for HOLD cycles, then compares the
//             latch Q against the written data and acknowledges.
//  Revision : 1.0 - initial release
// ============================================================================
module latch_write_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                       CK,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]           q_in,
    output logic                       le,
    output logic [WIDTH-1:0]           d_out,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic [N_REQ-1:0]           ack,
    output logic                       err,
    output logic                       busy
);

    localparam int c_IDX_W = $clog2(N_REQ);
    // One extra bit so ptr + offset cannot overflow before the wrap subtract.
    localparam int c_SUM_W = c_IDX_W + 1;
    // The hold counter only needs to reach HOLD-1.
    localparam int c_CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_HOLD  = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_IDX_W-1:0]   ptr_q, ptr_d;
    logic [c_IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic [WIDTH-1:0]     d_out_q, d_out_d;
    logic                 le_q, le_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic                 win_found;
    logic [c_IDX_W-1:0]   win_idx;
    logic [c_SUM_W-1:0]   cand;

    // Round-robin search: first asserted request at or after the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + c_SUM_W'(i);
            if (cand >= c_SUM_W'(N_REQ)) begin
                cand = cand - c_SUM_W'(N_REQ);
            end
            if (!win_found && req[cand[c_IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[c_IDX_W-1:0];
            end
        end
    end

    // Sequencer next state; every output is computed one edge early so the
    // ports come straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        d_out_d  = d_out_q;
        le_d     = 1'b0;
        ack_d    = '0;
        err_d    = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_id_d = win_idx;
                    d_out_d  = data_in[win_idx*WIDTH +: WIDTH];
                    state_d  = S_SETUP;
                    busy_d   = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_HOLD;
                cnt_d   = c_CNT_W'(HOLD - 1);
                le_d    = 1'b1;
                busy_d  = 1'b1;
            end
            S_HOLD: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    // Q is sampled on the last transparent edge, where the
                    // latch output has had the whole hold window to settle.
                    state_d         = S_CHECK;
                    ack_d[gnt_id_q] = 1'b1;
                    err_d           = (q_in != d_out_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    le_d  = 1'b1;
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                ptr_d   = (gnt_id_q == c_IDX_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            d_out_q  <= '0;
            le_q     <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            d_out_q  <= d_out_d;
            le_q     <= le_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign le     = le_q;
    assign d_out  = d_out_q;
    assign gnt_id = gnt_id_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_latch_write_arbiter
//  Purpose  : Self-checking bench for latch_write_arbiter. A transaction-level
//             reference (position within a write, round-robin pointer) gives
//             the expected outputs every cycle; directed scenarios cover the
//             reset, grant ordering, read-back error and abort cases, followed
//             by a randomized run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_latch_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 2;

    logic           CK;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic [W-1:0]   q_in;
    logic           le;
    logic [W-1:0]   d_out;
    logic [1:0]     gnt_id;
    logic [N-1:0]   ack;
    logic           err;
    logic           busy;

    logic [W-1:0]   q_lat = '0;
    logic           tie_zero;

    int checks = 0;
    int errors = 0;

    latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD(H)) dut (
        .CK(CK), .reset(reset), .req(req), .data_in(data_in), .q_in(q_in),
        .le(le), .d_out(d_out), .gnt_id(gnt_id), .ack(ack), .err(err), .busy(busy)
    );

    initial CK = 1'b0;
    always #10 CK = ~CK;

    // Behavioural shared latch: transparent while le is high.
    always @(le or d_out) if (le) q_lat = d_out;
    assign q_in = tie_zero ? '0 : q_lat;

    // Reference: m_t is the cycle index within a write (0 = idle,
    // 1 = setup, 2..H+1 = enable high, H+2 = acknowledge).
    int         m_t, m_ptr, m_gnt, m_w;
    logic [W-1:0] m_dout;
    logic       m_err;

    always @(posedge CK or posedge reset) begin
        if (reset) begin
            m_t = 0; m_ptr = 0; m_gnt = 0; m_dout = '0; m_err = 1'b0;
        end else if (m_t == 0) begin
            if (req != '0) begin
                m_w = -1;
                for (int i = 0; i < N; i++)
                    if (m_w < 0 && req[(m_ptr + i) % N]) m_w = (m_ptr + i) % N;
                m_gnt  = m_w;
                m_dout = data_in[m_w*W +: W];
                m_t    = 1;
            end
        end else if (m_t == H + 1) begin
            // Latch was transparent with our data, so Q equals it unless tied low.
            m_err = tie_zero ? (m_dout != '0) : 1'b0;
            m_t   = m_t + 1;
        end else if (m_t == H + 2) begin
            m_ptr = (m_gnt + 1) % N;
            m_t   = 0;
        end else begin
            m_t = m_t + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [N-1:0] e_ack;
        e_ack = (m_t == H + 2) ? (4'b0001 << m_gnt) : 4'b0000;
        chk("busy",   {31'b0, busy}, {31'b0, (m_t != 0)});
        chk("le",     {31'b0, le},   {31'b0, (m_t >= 2 && m_t <= H + 1)});
        chk("ack",    {28'b0, ack},  {28'b0, e_ack});
        chk("err",    {31'b0, err},  {31'b0, (m_t == H + 2) && m_err});
        chk("gnt_id", {30'b0, gnt_id}, m_gnt);
        chk("d_out",  {24'b0, d_out},  {24'b0, m_dout});
    endtask

    // Advance to the next falling edge and compare every output.
    task automatic step();
        @(negedge CK);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    int           le_cnt, ack_cnt;
    logic [N-1:0] seen_ack;
    logic         seen_err, got;
    logic [1:0]   seen_gnt;
    int           ack_ids[$];
    int           ack_cyc[$];
    int           exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // 1: reset held with all requests pending
        reset = 1'b1; req = 4'hF; data_in = $urandom; tie_zero = 1'b0;
        @(negedge CK);
        chk("t1_le",   {31'b0, le},   0);
        chk("t1_ack",  {28'b0, ack},  0);
        chk("t1_busy", {31'b0, busy}, 0);
        chk("t1_dout", {24'b0, d_out}, 0);
        #15 reset = 1'b0;
        step();
        step();
        chk("t1_first_gnt", {30'b0, gnt_id}, 0);
        req = '0;
        idle(8);

        // 2: single request from requester 2
        req = 4'b0100; data_in[23:16] = 8'hA5;
        le_cnt = 0; ack_cnt = 0; seen_ack = '0; seen_err = 1'b0; seen_gnt = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (le) le_cnt++;
            if (ack != '0) begin
                ack_cnt++; seen_ack = ack; seen_err = err; seen_gnt = gnt_id; req = '0;
            end
        end
        chk("t2_le_cycles", le_cnt, 2);
        chk("t2_ack_count", ack_cnt, 1);
        chk("t2_ack",  {28'b0, seen_ack}, 32'h4);
        chk("t2_err",  {31'b0, seen_err}, 0);
        chk("t2_gnt",  {30'b0, seen_gnt}, 2);

        // 3: all four requesting continuously from a fresh pointer
        reset = 1'b1; #2 reset = 1'b0;
        req = 4'hF; data_in = $urandom;
        for (int c = 0; c < 40 && ack_ids.size() < 5; c++) begin
            step();
            if (ack != '0) begin
                ack_ids.push_back(onehot_idx(ack));
                ack_cyc.push_back(c);
                if (ack_ids.size() == 5) req = '0;
            end
        end
        chk("t3_ack_count", ack_ids.size(), 5);
        for (int i = 0; i < ack_ids.size(); i++) begin
            chk("t3_order", ack_ids[i], exp_order[i]);
            if (i > 0) chk("t3_spacing", ack_cyc[i] - ack_cyc[i-1], H + 3);
        end
        idle(6);

        // 4: latch Q stuck at zero makes the read-back fail
        tie_zero = 1'b1; req = 4'b0010; data_in[15:8] = 8'h3C; got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            if (ack != '0) begin
                got = 1'b1;
                chk("t4_ack", {28'b0, ack}, 32'h2);
                chk("t4_err", {31'b0, err}, 1);
                req = '0;
            end
        end
        chk("t4_ack_seen", {31'b0, got}, 1);
        idle(4);
        tie_zero = 1'b0;

        // 5: reset during the enable window of a write from requester 3
        req = 4'b1000; data_in[31:24] = 8'h96; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (m_t == 2) got = 1'b1;
        end
        chk("t5_reached_hold", {31'b0, got}, 1);
        chk("t5_le_before", {31'b0, le}, 1);
        reset = 1'b1;
        #1;
        chk("t5_le_drop",   {31'b0, le},   0);
        chk("t5_busy_drop", {31'b0, busy}, 0);
        chk("t5_ack_none",  {28'b0, ack},  0);
        req = 4'b1001;
        step();
        reset = 1'b0;
        step();
        chk("t5_gnt_after", {30'b0, gnt_id}, 0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (ack != '0) begin
                got = 1'b1;
                chk("t5_first_ack", {28'b0, ack}, 32'h1);
                req = '0;
            end
        end
        chk("t5_ack_seen", {31'b0, got}, 1);
        idle(6);

        // 6: requester 1 drops during setup; requester 3 arrives in the ack cycle
        req = 4'b0010; data_in[15:8] = 8'h5A; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (m_t == 1) begin got = 1'b1; req = '0; end
        end
        chk("t6_reached_setup", {31'b0, got}, 1);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            if (ack != '0) begin
                got = 1'b1;
                chk("t6_ack", {28'b0, ack}, 32'h2);
                req = 4'b1000;
            end
        end
        chk("t6_ack_seen", {31'b0, got}, 1);
        step();
        chk("t6_idle_gap", {31'b0, busy}, 0);
        step();
        chk("t6_next_gnt", {30'b0, gnt_id}, 3);
        chk("t6_next_busy", {31'b0, busy}, 1);
        req = '0;
        idle(6);

        // Randomized traffic, read-back faults and occasional resets
        for (int c = 0; c < 400; c++) begin
            step();
            req      = 4'($urandom_range(0, 15));
            data_in  = $urandom;
            tie_zero = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1; #1 reset = 1'b0;
            end
        end
        req = '0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
